// File: rtl/dcpu_bus_pkg.sv
// Shared dcpu bus definitions: lane indices, strobe encodings, bridge states.
package dcpu_bus_pkg;

    localparam int LANE_LO = 0;
    localparam int LANE_HI = 1;

    localparam logic [1:0] STB_NONE = 2'b00;
    localparam logic [1:0] STB_LO   = 2'b01;
    localparam logic [1:0] STB_HI   = 2'b10;
    localparam logic [1:0] STB_HALF = 2'b11;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_LO   = 2'd1,
        BR_HI   = 2'd2,
        BR_ACK  = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/dcpu_wait_timer.sv
// Wait-state timer: cleared by load, counts up while enabled and holds at the
// terminal count TC. o_done is high on the cycle the count equals TC.
module dcpu_wait_timer #(
    parameter int             W  = 4,
    parameter logic [W-1:0]   TC = '0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_count,
    output logic o_done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign o_done = (cnt_q == TC);

    // Next count: load clears, count advances until terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = '0;
        end else if (i_count && !o_done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dcpu_mem8_bridge.sv
// 16-bit dcpu bus slave driving an 8-bit external SRAM/flash port with
// programmable wait states. Each strobed lane becomes one byte phase.
//
// state | meaning
// IDLE  | waiting for i_cyc with a non-zero strobe; request latched on accept
// LO    | byte phase for lane 0, WAIT+1 cycles
// HI    | optional one-cycle turnaround gap (gap_q), then lane 1 byte phase
// ACK   | one-cycle o_ack with masked read data
module dcpu_mem8_bridge
    import dcpu_bus_pkg::*;
#(
    parameter int ADDR_W = 19,
    parameter int WAIT   = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cyc,
    input  logic [1:0]        i_stb,
    input  logic              i_we,
    input  logic [31:0]       i_addr,
    input  logic [15:0]       i_dat,
    output logic [15:0]       o_dat,
    output logic              o_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_dat,
    input  logic [7:0]        i_mem_dat,
    output logic              o_mem_en,
    output logic              o_mem_we
);

    localparam logic [1:0] S_IDLE = BR_IDLE;
    localparam logic [1:0] S_LO   = BR_LO;
    localparam logic [1:0] S_HI   = BR_HI;
    localparam logic [1:0] S_ACK  = BR_ACK;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:1] addr_q,  addr_d;
    logic [1:0]        stb_q,   stb_d;
    logic              we_q,    we_d;
    logic [15:0]       dat_q,   dat_d;
    logic [15:0]       rbuf_q,  rbuf_d;
    logic              gap_q,   gap_d;
    logic              abort_q, abort_d;

    logic phase_on;
    logic lane_hi;
    logic done;
    logic abort_now;

    // Lane select comes from bit position, so the CPU's bit0 and any address
    // bits above the external window are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{i_addr[31:ADDR_W], i_addr[0]};

    assign phase_on  = (state_q == S_LO) || ((state_q == S_HI) && !gap_q);
    assign lane_hi   = (state_q == S_HI);
    assign abort_now = abort_q || !i_cyc;

    dcpu_wait_timer #(
        .W  (4),
        .TC (4'(WAIT))
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (!phase_on),
        .i_count (phase_on),
        .o_done  (done)
    );

    // Next-state and request/read-buffer latching.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        stb_d   = stb_q;
        we_d    = we_q;
        dat_d   = dat_q;
        rbuf_d  = rbuf_q;
        gap_d   = gap_q;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                if (i_cyc && (i_stb != STB_NONE)) begin
                    addr_d  = i_addr[ADDR_W-1:1];
                    stb_d   = i_stb;
                    we_d    = i_we;
                    dat_d   = i_dat;
                    rbuf_d  = '0;
                    gap_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = i_stb[LANE_LO] ? S_LO : S_HI;
                end
            end
            S_LO: begin
                if (!i_cyc) begin
                    abort_d = 1'b1;
                end
                if (done) begin
                    if (!we_q) begin
                        rbuf_d[7:0] = i_mem_dat;
                    end
                    if (abort_now) begin
                        state_d = S_IDLE;
                    end else if (stb_q[LANE_HI]) begin
                        state_d = S_HI;
                        gap_d   = 1'b1;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_HI: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                    if (abort_now) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (!i_cyc) begin
                        abort_d = 1'b1;
                    end
                    if (done) begin
                        if (!we_q) begin
                            rbuf_d[15:8] = i_mem_dat;
                        end
                        state_d = abort_now ? S_IDLE : S_ACK;
                    end
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            stb_q   <= STB_NONE;
            we_q    <= 1'b0;
            dat_q   <= '0;
            rbuf_q  <= '0;
            gap_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            rbuf_q  <= rbuf_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
        end
    end

    // Outputs decoded from registered state; idle values are all zero.
    always_comb begin
        o_mem_en   = phase_on;
        o_mem_we   = phase_on && we_q;
        o_mem_addr = phase_on ? {addr_q, lane_hi} : '0;
        o_mem_dat  = phase_on ? (lane_hi ? dat_q[15:8] : dat_q[7:0]) : 8'h00;
        o_ack      = (state_q == S_ACK);
        o_dat      = 16'h0000;
        if ((state_q == S_ACK) && !we_q) begin
            o_dat = {stb_q[LANE_HI] ? rbuf_q[15:8] : 8'h00,
                     stb_q[LANE_LO] ? rbuf_q[7:0]  : 8'h00};
        end
    end

endmodule
